// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard/stall control slice.
package pipeline_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } seq_state_e;

  localparam int CNT_W_DEFAULT        = 32;
  localparam int MAX_MEM_WAIT_DEFAULT = 15;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == {W{1'b1}}) ? v : v + W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/hazard_sequencer.sv
// Stage-control sequencer for a 5-stage pipeline: memory-wait stalls with timeout,
// redirect flushes, load-use bubbles, and stall/flush performance counters.
module hazard_sequencer
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEFAULT,
  parameter int MAX_MEM_WAIT = MAX_MEM_WAIT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             mem_access,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout
);

  localparam int WAIT_W = $clog2(MAX_MEM_WAIT + 1);

  seq_state_e        state_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [WAIT_W-1:0] wait_nxt;
  logic              release_q;
  logic              mem_wait;
  logic              load_use;
  logic              timeout_hit;
  logic              redirect_go;
  logic              stall_inc;
  logic              flush_inc;

  // release_q lets a timed-out access through for one cycle so MEM can drain.
  assign mem_wait = mem_access && !mem_ready && !release_q;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    wait_nxt    = (state_q == MEM_WAIT) ? wait_cnt_q + WAIT_W'(1) : WAIT_W'(1);
    timeout_hit = mem_wait && (wait_nxt == WAIT_W'(MAX_MEM_WAIT));
  end

  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pipe_hold   = 1'b0;
    redirect_go = 1'b0;
    if (reset) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (mem_wait) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_hold   = 1'b1;
    end else if (ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      redirect_go = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  assign stall_inc = !reset && !pc_write;
  assign flush_inc = redirect_go;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      release_q   <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      release_q <= 1'b0;
      if (timeout_hit) begin
        state_q     <= RUN;
        wait_cnt_q  <= '0;
        release_q   <= 1'b1;
        mem_timeout <= 1'b1;
      end else if (mem_wait) begin
        state_q    <= MEM_WAIT;
        wait_cnt_q <= wait_nxt;
      end else begin
        state_q    <= RUN;
        wait_cnt_q <= '0;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (reset),
    .en    (stall_inc),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (reset),
    .en    (flush_inc),
    .count (flush_count)
  );

endmodule
